alu_muldiv: RTL and testbench

- Iterative multiply/divide unit implementing the eight RV32M operations; sits beside the single-cycle ALU in the execute stage.
- Core issues an operation on a valid/ready handshake, stalls while the unit is busy, and consumes the result on a second valid/ready handshake.
- Generalises the combinational ALU in three ways: parametrised width, multi-cycle sequencing, and a registered result with a zero flag.

---
 rtl/alu_muldiv.sv | 215 +++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - iterative RV32M multiply/divide unit (ALU_MULDIV_FAST_MUL_EN: single-cycle multiply)
module alu_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  localparam int               CNT_W    = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Latched operation context
  logic [2:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   opnd_q;
  logic [2*XLEN-1:0] prod_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   result_q;
  logic              zero_q;

  // Input decode
  logic              in_is_div;
  logic              a_sgn, b_sgn;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              in_neg;
  logic              b_zero, div_ovf, special;
  logic [XLEN-1:0]   special_res;
  logic              go_done;
  logic [XLEN-1:0]   go_res;
  logic              accept;

  // Iteration datapath
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] prod_next;
  logic [XLEN-1:0]   calc_res;

  // Applies the deferred sign and picks the op's slice. For divide the low
  // half holds the quotient magnitude and the high half the remainder.
  function automatic logic [XLEN-1:0] finalize(input logic [2:0]        f_op,
                                               input logic              f_neg,
                                               input logic [2*XLEN-1:0] p);
    logic [2*XLEN-1:0] full;
    logic [XLEN-1:0]   q;
    logic [XLEN-1:0]   r;
    logic [XLEN-1:0]   res;
    full = f_neg ? -p : p;
    q    = f_neg ? -p[XLEN-1:0] : p[XLEN-1:0];
    r    = f_neg ? -p[2*XLEN-1:XLEN] : p[2*XLEN-1:XLEN];
    if (!f_op[2]) begin
      res = (f_op[1:0] == 2'b00) ? full[XLEN-1:0] : full[2*XLEN-1:XLEN];
    end else begin
      res = f_op[1] ? r : q;
    end
    return res;
  endfunction

  assign accept = (state_q == S_IDLE) && in_valid;

  // Operand signedness, magnitudes and the division corner cases
  always_comb begin
    in_is_div = op[2];
    a_sgn     = 1'b0;
    b_sgn     = 1'b0;
    if (in_is_div) begin
      a_sgn = ~op[0];
      b_sgn = ~op[0];
    end else begin
      a_sgn = (op == 3'b001) || (op == 3'b010);
      b_sgn = (op == 3'b001);
    end
    a_neg       = a_sgn & A[XLEN-1];
    b_neg       = b_sgn & B[XLEN-1];
    a_mag       = a_neg ? -A : A;
    b_mag       = b_neg ? -B : B;
    in_neg      = (in_is_div && op[1]) ? a_neg : (a_neg ^ b_neg);
    b_zero      = (B == '0);
    div_ovf     = in_is_div && !op[0] && (A == MOST_NEG) && (&B);
    special     = in_is_div && (b_zero || div_ovf);
    special_res = b_zero ? (op[1] ? A : '1) : (op[1] ? '0 : A);
  end

`ifdef ALU_MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  logic [XLEN-1:0]   fast_res;

  // Whole product in one cycle; divide still goes through CALC
  always_comb begin
    fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
    fast_res  = finalize(op, in_neg, fast_prod);
    go_done   = special || !in_is_div;
    go_res    = special ? special_res : fast_res;
  end
`else
  // Only the division corner cases skip CALC
  always_comb begin
    go_done = special;
    go_res  = special_res;
  end
`endif

  // One shift-add or one restoring-divide step on the shared product register
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, (prod_q[0] ? opnd_q : '0)};
    mul_next  = {mul_sum, prod_q[XLEN-1:1]};
    div_shift = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_diff  = div_shift[XLEN-1:0] - opnd_q;
    div_next  = {(div_ge ? div_diff : div_shift[XLEN-1:0]), prod_q[XLEN-2:0], div_ge};
    prod_next = op_q[2] ? div_next : mul_next;
    calc_res  = finalize(op_q, neg_q, prod_next);
  end

  // State register
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_d = go_done ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (cnt_q == CNT_ONE) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture, iteration and result registration
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      op_q     <= '0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else if (accept) begin
      op_q  <= op;
      neg_q <= in_neg;
      cnt_q <= CNT_LOAD;
      if (in_is_div) begin
        opnd_q <= b_mag;
        prod_q <= {{XLEN{1'b0}}, a_mag};
      end else begin
        opnd_q <= a_mag;
        prod_q <= {{XLEN{1'b0}}, b_mag};
      end
      if (go_done) begin
        result_q <= go_res;
        zero_q   <= (go_res == '0);
      end
    end else if (state_q == S_CALC) begin
      prod_q <= prod_next;
      cnt_q  <= cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        result_q <= calc_res;
        zero_q   <= (calc_res == '0);
      end
    end
  end

  assign result = result_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - scoreboard bench for alu_muldiv (XLEN=32)
module tb_alu_muldiv;

`ifdef ALU_MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        CLK = 1'b0;
  logic        RST_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    logic        z;
    int          lat;
  } exp_t;

  exp_t exp_q[$];

  alu_muldiv #(.XLEN(32)) dut (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic exp_t model(input logic [2:0] f_op, input logic [31:0] a, input logic [31:0] b);
    exp_t               e;
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] ub;
    logic [63:0]        p;
    logic               bz;
    logic               ovf;
    sa    = {{32{a[31]}}, a};
    sb    = {{32{b[31]}}, b};
    ub    = {32'd0, b};
    bz    = (b == 32'd0);
    ovf   = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    e.lat = MUL_LAT;
    p     = 64'd0;
    case (f_op)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; e.res = p[31:0]; end
      3'd1: begin p = sa * sb; e.res = p[63:32]; end
      3'd2: begin p = sa * ub; e.res = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; e.res = p[63:32]; end
      3'd4: e.res = bz ? 32'hFFFF_FFFF : (ovf ? a : 32'($signed(a) / $signed(b)));
      3'd5: e.res = bz ? 32'hFFFF_FFFF : a / b;
      3'd6: e.res = bz ? a : (ovf ? 32'd0 : 32'($signed(a) % $signed(b)));
      default: e.res = bz ? a : a % b;
    endcase
    if (f_op[2]) e.lat = (bz || (ovf && !f_op[0])) ? 1 : DIV_LAT;
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 300));
      default: return $urandom;
    endcase
  endfunction

  // Issues one op, measures edges from accept to out_valid, then consumes it
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic z, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge CLK); #1; n++;
    end
    op = o; A = a; B = b; in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    A = $urandom; B = $urandom; op = 3'($urandom_range(0, 7));
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge CLK); #1; lat++;
    end
    if (!out_valid) lat = -1;
    res = result;
    z = zero;
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 RST_n = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result got %h expected 0", result); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %b expected 1", zero); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    @(negedge CLK);
    RST_n = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_mul();
    logic [2:0]  ops [4] = '{3'd0, 3'd1, 3'd3, 3'd2};
    logic [31:0] as  [4] = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] bs  [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] rs  [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF};
    logic [31:0] r;
    logic        z;
    int          lat;
    exp_t        e;
    for (int i = 0; i < 10; i++) begin
      logic [2:0]  o;
      logic [31:0] a, b;
      if (i < 4) begin
        o = ops[i]; a = as[i]; b = bs[i];
        exp_q.push_back('{res: rs[i], z: 1'b0, lat: MUL_LAT});
      end else begin
        o = 3'($urandom_range(0, 3)); a = rand_operand(); b = rand_operand();
        exp_q.push_back(model(o, a, b));
      end
      do_op(o, a, b, r, z, lat);
      e = exp_q.pop_front();
      checks++; if (r !== e.res) begin errors++; $display("FAIL mul_result op=%0d a=%h b=%h got %h expected %h", o, a, b, r, e.res); end
      checks++; if (z !== e.z) begin errors++; $display("FAIL mul_zero op=%0d got %b expected %b", o, z, e.z); end
      checks++; if (lat != e.lat) begin errors++; $display("FAIL mul_latency op=%0d got %0d expected %0d", o, lat, e.lat); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] as  [4] = '{32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd100, 32'd100};
    logic [31:0] bs  [4] = '{32'd6, 32'd6, 32'd7, 32'd7};
    logic [31:0] rs  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd14, 32'd2};
    logic [31:0] r;
    logic        z;
    int          lat;
    exp_t        e;
    for (int i = 0; i < 10; i++) begin
      logic [2:0]  o;
      logic [31:0] a, b;
      if (i < 4) begin
        o = ops[i]; a = as[i]; b = bs[i];
        exp_q.push_back('{res: rs[i], z: 1'b0, lat: DIV_LAT});
      end else begin
        o = 3'($urandom_range(4, 7)); a = rand_operand(); b = rand_operand();
        exp_q.push_back(model(o, a, b));
      end
      do_op(o, a, b, r, z, lat);
      e = exp_q.pop_front();
      checks++; if (r !== e.res) begin errors++; $display("FAIL div_result op=%0d a=%h b=%h got %h expected %h", o, a, b, r, e.res); end
      checks++; if (z !== e.z) begin errors++; $display("FAIL div_zero op=%0d got %b expected %b", o, z, e.z); end
      checks++; if (lat != e.lat) begin errors++; $display("FAIL div_latency op=%0d got %0d expected %0d", o, lat, e.lat); end
    end
  endtask

  task automatic test_special();
    logic [2:0]  ops [4] = '{3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] rs  [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    logic        zs  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] r;
    logic        z;
    int          lat;
    exp_t        e;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{res: rs[i], z: zs[i], lat: 1});
      do_op(ops[i], as[i], bs[i], r, z, lat);
      e = exp_q.pop_front();
      checks++; if (r !== e.res) begin errors++; $display("FAIL special_result op=%0d got %h expected %h", ops[i], r, e.res); end
      checks++; if (z !== e.z) begin errors++; $display("FAIL special_zero op=%0d got %b expected %b", ops[i], z, e.z); end
      checks++; if (lat != e.lat) begin errors++; $display("FAIL special_latency op=%0d got %0d expected %0d", ops[i], lat, e.lat); end
    end
  endtask

  task automatic test_backpressure();
    int   n;
    exp_t e;
    exp_q.push_back('{res: 32'd30, z: 1'b0, lat: MUL_LAT});
    op = 3'd0; A = 32'd5; B = 32'd6; in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 200) begin
      @(posedge CLK); #1; n++;
    end
    e = exp_q.pop_front();
    checks++; if (!out_valid) begin errors++; $display("FAIL bp_out_valid got timeout expected valid within 200 edges"); end
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin op = 3'd5; A = 32'd1; B = 32'd0; in_valid = 1'b1; end
      if (i == 5) in_valid = 1'b0;
      @(posedge CLK); #1;
      checks++;
      if (result !== e.res || zero !== e.z || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold cycle=%0d got result=%h zero=%b in_ready=%b out_valid=%b expected %h %b 0 1",
                 i, result, zero, in_ready, out_valid, e.res, e.z);
      end
    end
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got %b expected 0", out_valid); end
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_no_stray_op got out_valid=%b busy=%b expected 0 0", out_valid, busy); end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] r;
    logic        z;
    int          lat;
    exp_t        e;
    op = 3'd4; A = 32'd1000; B = 32'd7; in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge CLK);
    #2;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before got %b expected 1", busy); end
    RST_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready got %b expected 1", in_ready); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL rst_mid_result got %h expected 0", result); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL rst_mid_zero got %b expected 1", zero); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b expected 0", busy); end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_n = 1'b1;
    repeat (40) begin
      @(posedge CLK); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_no_output got out_valid=%b expected 0", out_valid); end
    end
    exp_q.push_back(model(3'd0, 32'd3, 32'd4));
    do_op(3'd0, 32'd3, 32'd4, r, z, lat);
    e = exp_q.pop_front();
    checks++; if (r !== 32'd12 || r !== e.res) begin errors++; $display("FAIL rst_mid_mul got %h expected %h", r, e.res); end
    checks++; if (lat != MUL_LAT) begin errors++; $display("FAIL rst_mid_mul_latency got %0d expected %0d", lat, MUL_LAT); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    logic        z;
    int          lat;
    exp_t        e;
    for (int i = 0; i < 12; i++) begin
      logic [2:0]  o;
      logic [31:0] a, b;
      o = 3'($urandom_range(0, 7)); a = rand_operand(); b = rand_operand();
      exp_q.push_back(model(o, a, b));
      do_op(o, a, b, r, z, lat);
      e = exp_q.pop_front();
      checks++;
      if (r !== e.res || z !== e.z || lat != e.lat) begin
        errors++;
        $display("FAIL b2b op=%0d a=%h b=%h got %h/%b/%0d expected %h/%b/%0d", o, a, b, r, z, lat, e.res, e.z, e.lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
